// File: rtl/registers.sv
// 32-entry, two-read one-write register file with r0 hardwired to zero.
// Optional write-to-read forwarding when REGISTERS_BYPASS_EN is defined.
module registers #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wenable,
  input  logic [ADDR_WIDTH-1:0] i_addres_rs,
  input  logic [ADDR_WIDTH-1:0] i_addres_rt,
  input  logic [ADDR_WIDTH-1:0] i_addres_rd,
  input  logic [DATA_WIDTH-1:0] i_data_rd,
  output logic [DATA_WIDTH-1:0] o_data_rs,
  output logic [DATA_WIDTH-1:0] o_data_rt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_wr_ok;
  logic [DATA_WIDTH-1:0] w_rs_stored;
  logic [DATA_WIDTH-1:0] w_rt_stored;

  assign w_wr_ok = i_wenable && (i_addres_rd != '0);

  // Storage update: reset clears every entry and wins over a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[i_addres_rd] <= i_data_rd;
    end
  end

  assign w_rs_stored =
    (i_addres_rs == '0) ? '0 : r_mem[i_addres_rs];
  assign w_rt_stored =
    (i_addres_rt == '0) ? '0 : r_mem[i_addres_rt];

`ifdef REGISTERS_BYPASS_EN
  logic w_fwd_rs;
  logic w_fwd_rt;

  assign w_fwd_rs = w_wr_ok && !rst &&
                    (i_addres_rd == i_addres_rs);
  assign w_fwd_rt = w_wr_ok && !rst &&
                    (i_addres_rd == i_addres_rt);

  // Read ports, forwarding in-flight write data.
  always_comb begin
    o_data_rs = w_fwd_rs ? i_data_rd : w_rs_stored;
    o_data_rt = w_fwd_rt ? i_data_rd : w_rt_stored;
  end
`else
  // Read ports return the stored value only.
  always_comb begin
    o_data_rs = w_rs_stored;
    o_data_rt = w_rt_stored;
  end
`endif

endmodule

// File: tb/tb_registers.sv
// Directed self-checking bench for the registers block.
// Expected values are hand-computed per scenario.
module tb_registers;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          wen;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [AW-1:0] rd;
  logic [DW-1:0] din;
  logic [DW-1:0] ors;
  logic [DW-1:0] ort;

  int checks;
  int errors;

  registers #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_wenable  (wen),
    .i_addres_rs(rs),
    .i_addres_rt(rt),
    .i_addres_rd(rd),
    .i_data_rd  (din),
    .o_data_rs  (ors),
    .o_data_rt  (ort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    @(negedge clk);
    wen = 1'b1;
    rd  = a;
    din = d;
    @(posedge clk);
    #1;
    wen = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a,
                        input logic [AW-1:0] b);
    rs = a;
    rt = b;
    #1;
  endtask

  task automatic test_reset();
    do_write(5'd3, 32'h1234_0003);
    do_reset();
    set_rd(5'd3, 5'd31);
    checks++;
    if (ors !== 32'h0) begin
      errors++;
      $display("FAIL reset_rs3 got %h exp %h", ors, 32'h0);
    end
    checks++;
    if (ort !== 32'h0) begin
      errors++;
      $display("FAIL reset_rt31 got %h exp %h", ort, 32'h0);
    end
  endtask

  task automatic test_write_read();
    do_write(5'd3, 32'hFF01_0000);
    do_write(5'd1, 32'hFF01_0011);
    set_rd(5'd1, 5'd0);
    checks++;
    if (ors !== 32'hFF01_0011) begin
      errors++;
      $display("FAIL wr_rs1 got %h exp %h", ors, 32'hFF01_0011);
    end
    checks++;
    if (ort !== 32'h0) begin
      errors++;
      $display("FAIL wr_rt0 got %h exp %h", ort, 32'h0);
    end
    set_rd(5'd0, 5'd3);
    checks++;
    if (ors !== 32'h0) begin
      errors++;
      $display("FAIL wr_rs0 got %h exp %h", ors, 32'h0);
    end
    checks++;
    if (ort !== 32'hFF01_0000) begin
      errors++;
      $display("FAIL wr_rt3 got %h exp %h", ort, 32'hFF01_0000);
    end
  endtask

  task automatic test_r0();
    do_write(5'd0, 32'hDEAD_BEEF);
    set_rd(5'd0, 5'd0);
    checks++;
    if (ors !== 32'h0) begin
      errors++;
      $display("FAIL r0_rs got %h exp %h", ors, 32'h0);
    end
    checks++;
    if (ort !== 32'h0) begin
      errors++;
      $display("FAIL r0_rt got %h exp %h", ort, 32'h0);
    end
  endtask

  task automatic test_no_write();
    @(negedge clk);
    wen = 1'b0;
    rd  = 5'd9;
    din = 32'h5555_5555;
    @(posedge clk);
    #1;
    set_rd(5'd9, 5'd1);
    checks++;
    if (ors !== 32'h0) begin
      errors++;
      $display("FAIL nowr_r9 got %h exp %h", ors, 32'h0);
    end
    checks++;
    if (ort !== 32'hFF01_0011) begin
      errors++;
      $display("FAIL nowr_r1 got %h exp %h", ort, 32'hFF01_0011);
    end
  endtask

  task automatic test_back_to_back();
    do_write(5'd10, 32'h0000_00A0);
    do_write(5'd11, 32'h0000_00B0);
    do_write(5'd11, 32'h0000_00B1);
    set_rd(5'd10, 5'd11);
    checks++;
    if (ors !== 32'h0000_00A0) begin
      errors++;
      $display("FAIL b2b_r10 got %h exp %h", ors, 32'hA0);
    end
    checks++;
    if (ort !== 32'h0000_00B1) begin
      errors++;
      $display("FAIL b2b_r11 got %h exp %h", ort, 32'hB1);
    end
  endtask

  task automatic test_reset_priority();
    do_write(5'd5, 32'h1234_5678);
    set_rd(5'd5, 5'd3);
    checks++;
    if (ors !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rp_pre_r5 got %h exp %h", ors, 32'h1234_5678);
    end
    @(negedge clk);
    rst = 1'b1;
    wen = 1'b1;
    rd  = 5'd5;
    din = 32'hAAAA_AAAA;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wen = 1'b0;
    set_rd(5'd5, 5'd3);
    checks++;
    if (ors !== 32'h0) begin
      errors++;
      $display("FAIL rp_r5 got %h exp %h", ors, 32'h0);
    end
    checks++;
    if (ort !== 32'h0) begin
      errors++;
      $display("FAIL rp_r3 got %h exp %h", ort, 32'h0);
    end
  endtask

  task automatic test_rdw();
    logic [DW-1:0] exp_pre;
`ifdef REGISTERS_BYPASS_EN
    exp_pre = 32'h0BAD_F00D;
`else
    exp_pre = 32'h0;
`endif
    @(negedge clk);
    wen = 1'b1;
    rd  = 5'd7;
    din = 32'h0BAD_F00D;
    set_rd(5'd7, 5'd7);
    checks++;
    if (ors !== exp_pre) begin
      errors++;
      $display("FAIL rdw_pre_rs got %h exp %h", ors, exp_pre);
    end
    checks++;
    if (ort !== exp_pre) begin
      errors++;
      $display("FAIL rdw_pre_rt got %h exp %h", ort, exp_pre);
    end
    @(posedge clk);
    #1;
    wen = 1'b0;
    set_rd(5'd7, 5'd0);
    checks++;
    if (ors !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL rdw_post got %h exp %h", ors, 32'h0BAD_F00D);
    end
    @(negedge clk);
    wen = 1'b1;
    rd  = 5'd0;
    din = 32'h7777_7777;
    set_rd(5'd0, 5'd0);
    checks++;
    if (ors !== 32'h0) begin
      errors++;
      $display("FAIL rdw_r0 got %h exp %h", ors, 32'h0);
    end
    rst = 1'b1;
    rd  = 5'd7;
    din = 32'h1111_1111;
    set_rd(5'd7, 5'd7);
    checks++;
    if (ors !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL rdw_rst_fwd got %h exp %h", ors, 32'h0BAD_F00D);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    wen = 1'b0;
    set_rd(5'd7, 5'd7);
    checks++;
    if (ort !== 32'h0) begin
      errors++;
      $display("FAIL rdw_rst_clr got %h exp %h", ort, 32'h0);
    end
  endtask

  task automatic test_max();
    do_write(5'd31, 32'hFFFF_FFFF);
    set_rd(5'd31, 5'd31);
    checks++;
    if (ors !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL max_rs got %h exp %h", ors, 32'hFFFF_FFFF);
    end
    checks++;
    if (ort !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL max_rt got %h exp %h", ort, 32'hFFFF_FFFF);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    wen = 1'b0;
    rs  = '0;
    rt  = '0;
    rd  = '0;
    din = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_r0();
    test_no_write();
    test_back_to_back();
    test_reset_priority();
    test_rdw();
    test_max();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/registers.md
REGISTERS -- requirements
Module: registers

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 32, the width of each register and of each data port.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 5, the address width; depth is 2**ADDR_WIDTH (32 registers).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_wenable  input  1  write enable for the rd write port.
REQ-006 i_addres_rs  input  ADDR_WIDTH  read address, port rs.
REQ-007 i_addres_rt  input  ADDR_WIDTH  read address, port rt.
REQ-008 i_addres_rd  input  ADDR_WIDTH  write address, port rd.
REQ-009 i_data_rd  input  DATA_WIDTH  write data.
REQ-010 o_data_rs  output  DATA_WIDTH  read data for i_addres_rs.
REQ-011 o_data_rt  output  DATA_WIDTH  read data for i_addres_rt.

Function
REQ-012 Storage SHALL be 2**ADDR_WIDTH registers of DATA_WIDTH bits each.
REQ-013 Both read ports SHALL be combinational: zero-cycle latency, outputs follow address changes within the same cycle.
REQ-014 A write SHALL occur on the rising clk edge when i_wenable=1 and rst=0, storing i_data_rd into register i_addres_rd.
REQ-015 With i_wenable=0, no register SHALL change.
REQ-016 Register 0 SHALL be hardwired to zero: writes to address 0 are ignored, reads of address 0 return 0 on either port.
REQ-017 Both read ports SHALL be independent; rs and rt may address the same register simultaneously and both return its value.
REQ-018 Write data SHALL be visible on a read port no later than the cycle after the write edge.
REQ-019 Read during write to the same non-zero address SHALL behave as specified in Configuration.
REQ-020 Consecutive-cycle writes to different addresses SHALL all be retained; consecutive writes to the same address SHALL leave the last value.

Reset
REQ-021 When rst=1 at a rising clk edge, all registers SHALL clear to 0; both outputs then read 0 for any address.
REQ-022 Reset SHALL take priority over a simultaneous write; the write is discarded.
REQ-023 Reset asserted mid-operation SHALL clear all previously written values at that edge; no asynchronous path from rst to state or outputs.

Configuration
REQ-024 Macro REGISTERS_BYPASS_EN SHALL control write-to-read forwarding.
REQ-025 With REGISTERS_BYPASS_EN defined: when i_wenable=1, rst=0 and i_addres_rd is non-zero and equals a read address, that port SHALL output i_data_rd combinationally in the same cycle.
REQ-026 Without REGISTERS_BYPASS_EN: that port SHALL output the stored (pre-write) value until the write edge, then the new value.
REQ-027 Forwarding SHALL never apply to address 0 or while rst=1.

Verification
REQ-028 Assert rst=1 one edge, release; read rs=3, rt=31 -> both 0x00000000.
REQ-029 Write r3=0xFF010000, next cycle r1=0xFF010011, then wenable=0; rs=1, rt=0 -> o_data_rs=0xFF010011, o_data_rt=0x00000000; then rs=0, rt=3 -> 0x00000000, 0xFF010000.
REQ-030 Write r0=0xDEADBEEF; read rs=0, rt=0 -> both 0x00000000.
REQ-031 Write r5=0x12345678, then hold rst=1 with wenable=1, rd=5, data=0xAAAAAAAA for one edge; read r5 -> 0x00000000.
REQ-032 wenable=1, rd=7, data=0x0BADF00D, rs=7 before the edge -> 0x0BADF00D with REGISTERS_BYPASS_EN, prior value (0 after reset) without; after the edge 0x0BADF00D in both builds.
REQ-033 Write r31=0xFFFFFFFF, rs=rt=31 -> both ports 0xFFFFFFFF.
